nibble_serial_adder: RTL
========================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter SHALL be: WIDTH, 32, operand width in bits; multiple of 4, at least 8.
REQ-002 Port SHALL be: clk  in  1  single clock; every register updates on its rising edge.
REQ-003 Port SHALL be: rst_n  in  1  reset, synchronous and active-low.
REQ-004 Port SHALL be: in_valid  in  1  operand pair a/b (and sub) is valid.
REQ-005 Port SHALL be: in_ready  out  1  block can accept operands; high only in IDLE.
REQ-006 Port SHALL be: a, b  in  WIDTH each  operands, two's complement.
REQ-007 Port SHALL be: sub  in  1  1 selects a-b; present only under SERIAL_ADD_SUB_EN.
REQ-008 Port SHALL be: out_valid  out  1  result valid; high only in DONE.
REQ-009 Port SHALL be: out_ready  in  1  consumer accepts the result.
REQ-010 Port SHALL be: sum  out  WIDTH  result.
REQ-011 Port SHALL be: c_out  out  1  carry out of the MSB nibble.
REQ-012 Port SHALL be: ovf  out  1  signed overflow.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE; reset state is IDLE.
REQ-014 In IDLE, when in_valid=1 the block SHALL load a, b and sub into operand registers on that edge.
REQ-015 On that same edge it SHALL clear the nibble counter, load carry_reg with the initial carry (0 for add, 1 for sub) and move to RUN.
REQ-016 In RUN, each cycle SHALL pass nibble[cnt] of a and nibble[cnt] of b (b inverted when sub) with carry_reg through one 4-bit carry-lookahead slice.
REQ-017 Each RUN cycle SHALL write the slice sum into sum[4*cnt+3:4*cnt], write the slice carry into carry_reg and increment cnt.
REQ-018 cnt SHALL count from 0 to WIDTH/4-1; the edge that processes nibble WIDTH/4-1 SHALL move the FSM to DONE and wrap cnt to 0.
REQ-019 On that final RUN edge, c_out SHALL take the slice carry and ovf SHALL take the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-020 Latency: out_valid SHALL rise exactly WIDTH/4 edges after the accept edge (8 cycles for WIDTH=32); throughput is one operation per WIDTH/4+2 cycles at minimum.
REQ-021 In DONE, sum, c_out and ovf SHALL hold stable until out_ready=1; that edge SHALL move the FSM to IDLE.
REQ-022 in_valid in RUN or DONE SHALL be ignored; the operand registers SHALL not change.
REQ-023 out_ready outside DONE SHALL have no effect.
REQ-024 sum SHALL be modulo 2^WIDTH; c_out=1 on unsigned carry for add and on no-borrow for sub.

Reset
REQ-025 When rst_n=0 at an edge, the block SHALL enter IDLE and clear cnt, carry_reg, the operand registers, sum, c_out, ovf and out_valid to 0; in_ready is 1 after that edge.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid SHALL be produced for it.
REQ-027 Reset SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-028 Macro SERIAL_ADD_SUB_EN defined: the sub port SHALL exist, and sub=1 SHALL invert b nibbles and set the initial carry to 1.
REQ-029 Macro SERIAL_ADD_SUB_EN undefined: the sub port and the inversion logic SHALL be absent, and the initial carry SHALL be 0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), the nibble width constant 4 and the counter-width function clog2(WIDTH/4).
REQ-031 One sub-module, nibble_cla, SHALL hold the combinational 4-bit slice (p/g generation, carry chain, sum, carry into bit 3 for overflow).
REQ-032 nibble_serial_adder SHALL instantiate nibble_cla exactly once.

Verification
REQ-033 Scenario 1: a=0xFFFFFFFF, b=0x00000001, add -> after 8 cycles sum=0x00000000, c_out=1, ovf=0.
REQ-034 Scenario 2: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, c_out=0, ovf=1.
REQ-035 Scenario 3: out_ready held 0 for 5 cycles in DONE -> sum, c_out and ovf are stable, in_ready=0, and in_valid pulses are ignored.
REQ-036 Scenario 4: rst_n=0 at the 4th RUN cycle of 0x12345678+0x11111111 -> next cycle IDLE with all outputs 0; a new add then yields the correct result.
REQ-037 Scenario 5 (SERIAL_ADD_SUB_EN): sub=1, a=5, b=7 -> sum=0xFFFFFFFE, c_out=0, ovf=0; a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-038 Scenario 6: back-to-back operations with out_ready tied to 1 -> in_ready returns 1 exactly one cycle after out_valid, and every result matches a reference model over 1000 random pairs.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state enum, nibble width and counter-width helper.
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width / NIB_W);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// nibble_cla: combinational 4-bit carry-lookahead slice.
// c3_o is the carry into bit 3, used for signed overflow.
module nibble_cla (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o,
  output logic       c3_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o  = p ^ c[3:0];
  assign c_o  = c[4];
  assign c3_o = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial add (and optional subtract) over WIDTH bits.
// Define SERIAL_ADD_SUB_EN to add the sub port and a-b support.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NN = WIDTH / NIB_W;
  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CW+1:0]    base;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             c_nib, c3_nib, last;
  logic             init_c;

  assign base  = {cnt_q, 2'b00};
  assign a_nib = a_q[base +: NIB_W];
  assign last  = (cnt_q == CW'(NN - 1));

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;
  assign b_nib  = b_q[base +: NIB_W] ^ {NIB_W{sub_q}};
  assign init_c = sub;
`else
  assign b_nib  = b_q[base +: NIB_W];
  assign init_c = 1'b0;
`endif

  nibble_cla u_cla (
    .a_i  (a_nib),
    .b_i  (b_nib),
    .c_i  (carry_q),
    .s_o  (s_nib),
    .c_o  (c_nib),
    .c3_o (c3_nib)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      cnt_d   = '0;
      carry_d = init_c;
`ifdef SERIAL_ADD_SUB_EN
      sub_d   = sub;
`endif
    end else if (state_q == RUN) begin
      sum_d[base +: NIB_W] = s_nib;
      carry_d = c_nib;
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      if (last) begin
        cout_d = c_nib;
        ovf_d  = c3_nib ^ c_nib;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign sum   = sum_q;
  assign c_out = cout_q;
  assign ovf   = ovf_q;

endmodule
